pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. Combines the hazard detector's stall request, data-memory wait, and EX-stage branch resolution into per-stage register enables and flush (bubble) controls. Tracks a valid bit per stage and flags a stall timeout. Sits between the hazard/branch logic and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

## Interface
Parameters:
- MAX_STALL, 64: consecutive stalled cycles after which `timeout` sets; must be ≥ 2.
- CW, 7: width of `stall_cnt`; must satisfy 2^CW > MAX_STALL.

Ports (clock and reset first; one clock `clk`; reset `rst` is asynchronous and active-high):
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- hazard_stall  in  1  data-hazard stall request for the instruction in ID (1 = stall).
- mem_busy  in  1  data memory not ready; freezes the whole pipe.
- branch_taken  in  1  taken branch or jump resolved in EX.
- imem_ready  in  1  fetched word is valid this cycle.
- pc_en  out  1  PC load enable.
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline register enables.
- ifid_flush, idex_flush  out  1 each  load NOP/bubble into IF/ID or ID/EX.
- vld_id, vld_ex, vld_mem, vld_wb  out  1 each  stage holds a real instruction.
- state  out  2  RUN=0, STALL=1, MWAIT=2, FLUSH=3.
- stall_cnt  out  CW  current consecutive stall count.
- timeout  out  1  sticky stall-timeout flag.

## Operation
- Event priority per cycle: mem_busy > (branch_taken & vld_ex) > (hazard_stall & vld_id & state≠FLUSH) > none.
- mem_busy: all enables 0, flushes 0, valid bits hold; next state MWAIT. When mem_busy drops, next state is RUN and the remaining events are re-evaluated that cycle.
- Branch: pc_en=1, ifid_flush=1, idex_flush=1, exmem_en=memwb_en=1; next state FLUSH.
- FLUSH: lasts exactly 1 cycle; hazard_stall is ignored (ID holds a bubble); all enables 1; next state RUN unless mem_busy.
- Hazard: pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1, exmem_en=memwb_en=1; next state STALL. Stays in STALL while the hazard condition holds.
- None: all enables 1, flushes 0; next state RUN.
- Valid bits update on each clock edge:
  - vld_id ← imem_ready if ifid_en & ~ifid_flush; 0 if ifid_flush; otherwise hold.
  - vld_ex ← vld_id if idex_en & ~idex_flush; 0 if idex_flush.
  - vld_mem ← vld_ex if exmem_en.
  - vld_wb ← vld_mem if memwb_en.
- stall_cnt: increments in any cycle in which the next state is STALL or MWAIT, saturating at MAX_STALL. It clears to 0 on any other cycle.
- timeout: sets when stall_cnt reaches MAX_STALL and stays set until rst.

## Timing
- Enables and flushes are combinational from the current state and inputs; they respond in the same cycle.
- state, valid bits, stall_cnt and timeout are registered and update on the rising edge of clk.
- Reset values: state=RUN, all vld_*=0, stall_cnt=0, timeout=0. While rst=1, all enables are forced to 0 and both flushes to 1.
- Reset asserted mid-stall or mid-flush returns the block to RUN immediately; no pending event is retained.
- Load-use case: hazard_stall held for 1 cycle inserts exactly 1 bubble into EX.
- Branch penalty: exactly 2 bubbles (the ID and EX slots).
- mem_busy together with branch_taken: the branch is held, not lost; it is taken on the first cycle after mem_busy drops, provided vld_ex is still 1.
- Saturation: stall_cnt never exceeds MAX_STALL and does not wrap.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - Adds 32-bit outputs perf_bubbles and perf_flushes, reset to 0.
  - perf_bubbles increments on every cycle in which idex_flush is 1 because of a hazard.
  - perf_flushes increments once per branch event.
  - Both wrap modulo 2^32.
- PIPE_PERF_CNT_EN not defined: neither the counters nor their ports exist; all other behaviour is identical.

## Test plan
- Reset then run: rst high 3 cycles, then imem_ready=1 with no events → all enables 1 from the first cycle after rst drops; vld_wb=1 after the 4th clock edge.
- Load-use: hazard_stall=1 for 1 cycle with vld_id=1 → pc_en=0, ifid_en=0, idex_flush=1 that cycle; vld_ex=0 next cycle; state STALL→RUN; stall_cnt 1→0.
- Branch plus masked hazard: branch_taken=1 with vld_ex=1, then hazard_stall=1 in the next cycle → ifid_flush=idex_flush=1, state=FLUSH, hazard ignored, RUN on the following cycle.
- Mem wait with pending branch: mem_busy=1 for 5 cycles while branch_taken=1 → all enables 0, stall_cnt reaches 5; on release the flush occurs in the same cycle.
- Timeout: MAX_STALL=4, hazard_stall held for 6 cycles → timeout=1 at cycle 4, stall_cnt saturates at 4; timeout remains 1 after the stall ends until rst.
- With PIPE_PERF_CNT_EN: 3 load-use stalls and 2 branches → perf_bubbles=3, perf_flushes=2.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Bundle between the hazard/branch logic (master) and the pipeline sequencer (slave).
// Perf counters exist only when PIPE_PERF_CNT_EN is defined.
interface pipe_ctrl_if #(
  parameter int CW = 7
);
  logic          hazard_stall;
  logic          mem_busy;
  logic          branch_taken;
  logic          imem_ready;
  logic          pc_en;
  logic          ifid_en;
  logic          idex_en;
  logic          exmem_en;
  logic          memwb_en;
  logic          ifid_flush;
  logic          idex_flush;
  logic          vld_id;
  logic          vld_ex;
  logic          vld_mem;
  logic          vld_wb;
  logic [1:0]    state;
  logic [CW-1:0] stall_cnt;
  logic          timeout;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0]   perf_bubbles;
  logic [31:0]   perf_flushes;
`endif

  modport master (
    output hazard_stall, mem_busy, branch_taken, imem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
    input  vld_id, vld_ex, vld_mem, vld_wb, state, stall_cnt, timeout
`ifdef PIPE_PERF_CNT_EN
    , input perf_bubbles, perf_flushes
`endif
  );

  modport slave (
    input  hazard_stall, mem_busy, branch_taken, imem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
    output vld_id, vld_ex, vld_mem, vld_wb, state, stall_cnt, timeout
`ifdef PIPE_PERF_CNT_EN
    , output perf_bubbles, perf_flushes
`endif
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Purpose: 5-stage pipe sequencer (enables/flushes, per-stage valids, stall timeout); PIPE_PERF_CNT_EN adds perf counters.
// Latency: enables/flushes combinational same cycle; state/valids/counters registered on clk.
// Backpressure: mem_busy freezes every stage; hazard holds PC and IF/ID while a bubble enters EX.
module pipe_ctrl #(
  parameter int MAX_STALL = 64,
  parameter int CW        = 7
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    MWAIT = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [CW-1:0] LP_MAX = CW'(MAX_STALL);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_vld_id, r_vld_ex, r_vld_mem, r_vld_wb;
  logic [CW-1:0] r_stall_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_timeout;
  logic          w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en;
  logic          w_ifid_flush, w_idex_flush;
  logic          w_br, w_hz, w_br_evt, w_hz_evt, w_stalling;

  // Branch outranks hazard; ID holds a bubble during FLUSH so its hazard is ignored.
  assign w_br = bus.branch_taken & r_vld_ex;
  assign w_hz = bus.hazard_stall & r_vld_id & (r_state != FLUSH);

  always_comb begin
    w_pc_en      = 1'b1;
    w_ifid_en    = 1'b1;
    w_idex_en    = 1'b1;
    w_exmem_en   = 1'b1;
    w_memwb_en   = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    w_state_nxt  = RUN;
    w_br_evt     = 1'b0;
    w_hz_evt     = 1'b0;
    if (rst) begin
      w_pc_en      = 1'b0;
      w_ifid_en    = 1'b0;
      w_idex_en    = 1'b0;
      w_exmem_en   = 1'b0;
      w_memwb_en   = 1'b0;
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
    end else if (bus.mem_busy) begin
      w_pc_en     = 1'b0;
      w_ifid_en   = 1'b0;
      w_idex_en   = 1'b0;
      w_exmem_en  = 1'b0;
      w_memwb_en  = 1'b0;
      w_state_nxt = MWAIT;
    end else if (w_br) begin
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
      w_state_nxt  = FLUSH;
      w_br_evt     = 1'b1;
    end else if (w_hz) begin
      w_pc_en      = 1'b0;
      w_ifid_en    = 1'b0;
      w_idex_flush = 1'b1;
      w_state_nxt  = STALL;
      w_hz_evt     = 1'b1;
    end
  end

  assign w_stalling = (w_state_nxt == STALL) || (w_state_nxt == MWAIT);
  assign w_cnt_nxt  = !w_stalling ? '0 :
                      (r_stall_cnt == LP_MAX) ? r_stall_cnt : r_stall_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_vld_id    <= 1'b0;
      r_vld_ex    <= 1'b0;
      r_vld_mem   <= 1'b0;
      r_vld_wb    <= 1'b0;
      r_stall_cnt <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      if (w_ifid_flush)   r_vld_id <= 1'b0;
      else if (w_ifid_en) r_vld_id <= bus.imem_ready;
      if (w_idex_flush)   r_vld_ex <= 1'b0;
      else if (w_idex_en) r_vld_ex <= r_vld_id;
      if (w_exmem_en)     r_vld_mem <= r_vld_ex;
      if (w_memwb_en)     r_vld_wb  <= r_vld_mem;
      r_stall_cnt <= w_cnt_nxt;
      r_timeout   <= r_timeout | (w_cnt_nxt == LP_MAX);
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_perf_bubbles, r_perf_flushes;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_bubbles <= '0;
      r_perf_flushes <= '0;
    end else begin
      if (w_hz_evt) r_perf_bubbles <= r_perf_bubbles + 32'd1;
      if (w_br_evt) r_perf_flushes <= r_perf_flushes + 32'd1;
    end
  end

  assign bus.perf_bubbles = r_perf_bubbles;
  assign bus.perf_flushes = r_perf_flushes;
`endif

  assign bus.pc_en      = w_pc_en;
  assign bus.ifid_en    = w_ifid_en;
  assign bus.idex_en    = w_idex_en;
  assign bus.exmem_en   = w_exmem_en;
  assign bus.memwb_en   = w_memwb_en;
  assign bus.ifid_flush = w_ifid_flush;
  assign bus.idex_flush = w_idex_flush;
  assign bus.vld_id     = r_vld_id;
  assign bus.vld_ex     = r_vld_ex;
  assign bus.vld_mem    = r_vld_mem;
  assign bus.vld_wb     = r_vld_wb;
  assign bus.state      = r_state;
  assign bus.stall_cnt  = r_stall_cnt;
  assign bus.timeout    = r_timeout;

endmodule
